multi_mode_ff_bank: RTL and testbench
=====================================

// Module: multi_mode_ff_bank
//
// PURPOSE
//   Parametrised bank of WIDTH edge-triggered flip-flops; one shared mode select picks D, T, SR or JK operation.
//   Generalises the single-bit SR flip-flop: adds asynchronous reset, clock enable, defined behaviour for S=R=1,
//   and per-bit sticky illegal-input flags. Used as the general state-register primitive in sequential lab designs.
//
// PARAMETERS
//   WIDTH      8      number of independent flip-flop channels (1..64)
//   RESET_VAL  0      WIDTH-bit value loaded into q on reset
//
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous, active-high reset
//   en       in   1      clock enable; 0 = all channels hold
//   mode     in   2      00=D, 01=T, 10=SR, 11=JK (shared by all channels)
//   a        in   WIDTH  D / T / S / J input per channel
//   b        in   WIDTH  R / K input per channel; ignored in D and T modes
//   err_clr  in   1      synchronous clear of the err flags
//   q        out  WIDTH  flip-flop state
//   qbar     out  WIDTH  always ~q, combinational from q, never X after reset
//   err      out  WIDTH  sticky flag per channel: S=R=1 seen in SR mode
//
// BEHAVIOUR
//   - Reset: rst=1 forces q=RESET_VAL and err=0 immediately, regardless of clk. qbar=~RESET_VAL.
//     Deassertion takes effect at the next rising edge; reset mid-operation discards any pending update.
//   - All updates occur on the rising clk edge; latency is 1 cycle from input to q.
//   - mode is sampled at the same edge as a/b. A mode change applies to that edge; no state is cleared.
//   - en=0: q holds in every mode. err still clears if err_clr=1. No new err is set.
//   - Next state per channel i, when en=1:
//       D : q<=a[i]
//       T : q<=q[i]^a[i]
//       SR: 00 hold, 01 q<=0, 10 q<=1, 11 see SR_ILLEGAL_DET_EN
//       JK: 00 hold, 01 q<=0, 10 q<=1, 11 q<=~q[i]
//   - err[i] sets on an edge with en=1, mode=10, a[i]=b[i]=1. It stays set until err_clr or rst.
//   - err_clr=1 and a new set event in the same cycle: set wins, so err[i]=1 afterwards. Other bits clear.
//   - Channels are fully independent; no cross-channel interaction.
//
// CONFIGURATION
//   SR_ILLEGAL_DET_EN defined:
//     - SR mode with S=R=1 holds q and sets err[i] as described above.
//   SR_ILLEGAL_DET_EN undefined:
//     - SR mode with S=R=1 forces q<=0 (reset-dominant).
//     - err is tied to all zeros, and err_clr is ignored.
//
// TESTING (WIDTH=8, RESET_VAL=8'hA5, 20 ns clock)
//   1. rst=1 asserted between edges
//      -> q=8'hA5 and qbar=8'h5A within the same delta, before the next edge; err=0.
//   2. D mode, en=1, a=8'h3C
//      -> q=8'h3C after 1 edge. Then en=0 and a=8'hFF for 3 edges -> q stays 8'h3C.
//   3. T mode from q=8'h00, a=8'h0F
//      -> q sequence over 3 edges: 8'h0F, 8'h00, 8'h0F.
//   4. SR mode from q=8'h00: edge with a=8'hF0, b=8'h00 -> q=8'hF0.
//      Then edge with a=8'h0F, b=8'hF0 -> q=8'h0F.
//   5. SR mode, a=b=8'h81, q=8'h0F
//      -> with SR_ILLEGAL_DET_EN: q=8'h0F and err=8'h81. Then err_clr=1, en=0 -> err=8'h00.
//      -> without SR_ILLEGAL_DET_EN: q=8'h0E and err=8'h00.
//   6. JK mode from q=8'h55, a=b=8'hFF -> q=8'hAA, then 8'h55.
//      rst pulse mid-sequence -> q=8'hA5 asynchronously.

Source files
------------

// File: rtl/multi_mode_ff_bank.sv
// Bank of WIDTH flip-flops sharing one D/T/SR/JK mode select, with clock enable and async reset.
// Optional macro SR_ILLEGAL_DET_EN: SR with S=R=1 holds q and sets a sticky per-bit err flag.
module multi_mode_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] err
);

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_SR = 2'b10;
  localparam logic [1:0] MODE_JK = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;

  // SR next state; the S=R=1 case either holds or is reset-dominant.
  function automatic logic [WIDTH-1:0] sr_next(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] s,
                                               input logic [WIDTH-1:0] r);
`ifdef SR_ILLEGAL_DET_EN
    sr_next = (s & ~r) | (cur & ~(r & ~s));
`else
    sr_next = (s & ~r) | (cur & ~r);
`endif
  endfunction

  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode)
        MODE_D:  q_d = a;
        MODE_T:  q_d = q_q ^ a;
        MODE_SR: q_d = sr_next(q_q, a, b);
        MODE_JK: q_d = (a & ~q_q) | (~b & q_q);
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= RESET_VAL;
    else     q_q <= q_d;
  end

  assign q    = q_q;
  assign qbar = ~q_q;

`ifdef SR_ILLEGAL_DET_EN
  logic [WIDTH-1:0] err_q, err_d;
  logic [WIDTH-1:0] err_set;

  // A set event in the same cycle as err_clr wins for that bit.
  always_comb begin
    err_set = '0;
    if (en && (mode == MODE_SR)) err_set = a & b;
    err_d = (err_clr ? '0 : err_q) | err_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err            = '0;
`endif

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Self-checking bench for multi_mode_ff_bank: directed steps then random traffic vs a per-bit model.
module tb_multi_mode_ff_bank;
  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] a, b;
  logic         err_clr;
  logic [W-1:0] q, qbar, err;

  int nchecks = 0;
  int nerrs   = 0;

  logic [W-1:0] mq, merr;

  multi_mode_ff_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
    .err_clr(err_clr), .q(q), .qbar(qbar), .err(err)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"}, q, mq);
    check({tag, ".qbar"}, qbar, ~mq);
    check({tag, ".err"}, err, merr);
  endtask

  // Reference model: each channel treated as an independent textbook flip-flop.
  task automatic model_edge();
    logic [W-1:0] nq;
    nq = mq;
    if (err_clr) merr = '0;
    if (en) begin
      for (int i = 0; i < W; i++) begin
        int s, r, cur;
        s = a[i]; r = b[i]; cur = mq[i];
        if (mode == 2'd0)      nq[i] = (s == 1);
        else if (mode == 2'd1) nq[i] = ((cur + s) % 2) == 1;
        else if (mode == 2'd2) begin
          if (s == 1 && r == 0)      nq[i] = 1'b1;
          else if (s == 0 && r == 1) nq[i] = 1'b0;
          else if (s == 1 && r == 1) begin
`ifdef SR_ILLEGAL_DET_EN
            merr[i] = 1'b1;
`else
            nq[i] = 1'b0;
`endif
          end
        end else begin
          if (s == 1 && r == 0)      nq[i] = 1'b1;
          else if (s == 0 && r == 1) nq[i] = 1'b0;
          else if (s == 1 && r == 1) nq[i] = (cur == 0);
        end
      end
    end
    mq = nq;
  endtask

  // Called at a falling edge: apply inputs, take one rising edge, check at the next falling edge.
  task automatic step(input string tag, input logic [1:0] m, input logic [W-1:0] ai,
                      input logic [W-1:0] bi, input logic e, input logic ec);
    mode = m; a = ai; b = bi; en = e; err_clr = ec;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    mq = RV; merr = '0;
    check_all(tag);
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'd0; a = '0; b = '0; err_clr = 1'b0;
    mq = '0; merr = '0;
    #3 rst = 1'b1;
    #1;
    mq = RV; merr = '0;
    check_all("reset_init");
    @(negedge clk);
    rst = 1'b0;

    // D mode load and enable hold
    step("d_load", 2'd0, 8'h3C, 8'h00, 1'b1, 1'b0);
    check("d_load_const", q, 8'h3C);
    for (int k = 0; k < 3; k++) step("d_hold", 2'd0, 8'hFF, 8'h00, 1'b0, 1'b0);
    check("d_hold_const", q, 8'h3C);

    // T mode toggles
    step("t_zero", 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    step("t1", 2'd1, 8'h0F, 8'h00, 1'b1, 1'b0);
    check("t1_const", q, 8'h0F);
    step("t2", 2'd1, 8'h0F, 8'h00, 1'b1, 1'b0);
    check("t2_const", q, 8'h00);
    step("t3", 2'd1, 8'h0F, 8'h00, 1'b1, 1'b0);
    check("t3_const", q, 8'h0F);

    // SR set/reset
    step("sr_zero", 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    step("sr_set", 2'd2, 8'hF0, 8'h00, 1'b1, 1'b0);
    check("sr_set_const", q, 8'hF0);
    step("sr_rs", 2'd2, 8'h0F, 8'hF0, 1'b1, 1'b0);
    check("sr_rs_const", q, 8'h0F);

    // SR illegal input
    step("sr_ill", 2'd2, 8'h81, 8'h81, 1'b1, 1'b0);
`ifdef SR_ILLEGAL_DET_EN
    check("sr_ill_q_const", q, 8'h0F);
    check("sr_ill_err_const", err, 8'h81);
    step("sr_ill_hold", 2'd2, 8'h00, 8'h00, 1'b1, 1'b0);
    check("err_sticky_const", err, 8'h81);
    step("err_clr", 2'd2, 8'h81, 8'h81, 1'b0, 1'b1);
    check("err_clr_const", err, 8'h00);
    step("err_set_wins", 2'd2, 8'h03, 8'h02, 1'b1, 1'b0);
    step("err_set_wins2", 2'd2, 8'h10, 8'h10, 1'b1, 1'b1);
    check("err_set_wins_const", err, 8'h10);
`else
    check("sr_ill_q_const", q, 8'h0E);
    check("sr_ill_err_const", err, 8'h00);
`endif

    // JK toggle and async reset mid-sequence
    step("jk_load", 2'd0, 8'h55, 8'h00, 1'b1, 1'b0);
    step("jk1", 2'd3, 8'hFF, 8'hFF, 1'b1, 1'b0);
    check("jk1_const", q, 8'hAA);
    step("jk2", 2'd3, 8'hFF, 8'hFF, 1'b1, 1'b0);
    check("jk2_const", q, 8'h55);
    async_reset("jk_rst");
    check("jk_rst_const", q, 8'hA5);
    check("jk_rst_qbar_const", qbar, 8'h5A);
    step("after_rst", 2'd3, 8'h0F, 8'hF0, 1'b1, 1'b0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [1:0] rm;
      logic [W-1:0] ra, rb;
      logic re, rc;
      rm = 2'($urandom_range(0, 3));
      ra = W'($urandom);
      rb = W'($urandom);
      re = ($urandom_range(0, 5) != 0);
      rc = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) async_reset("rand_rst");
      step("rand", rm, ra, rb, re, rc);
    end

    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end

  initial begin
    #200000;
    nerrs++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $fatal(1, "timeout");
  end
endmodule
